// File: rtl/tone_pkg.sv
// Shared note constants and the violin divider table used by the tone
// generator and the tone decoder.
package tone_pkg;

    localparam int NOTE_W = 5;
    localparam logic [NOTE_W-1:0] NOTE_SILENCE = '0;
    localparam int NUM_NOTES = 17;
    localparam int M_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_SEARCH
    } dec_state_t;

    // Period of each note code in units of 2^SHIFT clocks; code 0 has no entry.
    function automatic logic [M_W-1:0] note_div(input logic [NOTE_W-1:0] k);
        case (k)
            5'd1:    note_div = 11'd948;
            5'd2:    note_div = 11'd844;
            5'd3:    note_div = 11'd797;
            5'd4:    note_div = 11'd710;
            5'd5:    note_div = 11'd632;
            5'd6:    note_div = 11'd596;
            5'd7:    note_div = 11'd531;
            5'd8:    note_div = 11'd473;
            5'd9:    note_div = 11'd421;
            5'd10:   note_div = 11'd398;
            5'd11:   note_div = 11'd354;
            5'd12:   note_div = 11'd315;
            5'd13:   note_div = 11'd297;
            5'd14:   note_div = 11'd265;
            5'd15:   note_div = 11'd236;
            5'd16:   note_div = 11'd210;
            5'd17:   note_div = 11'd198;
            default: note_div = '0;
        endcase
    endfunction

endpackage

// File: rtl/tone_decoder_note_matcher.sv
// Sequential table search: one divider entry per clock, codes 1..17, first
// entry within +/- D>>5 of the measured period wins.
module note_matcher
    import tone_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [M_W-1:0]    m,
    output logic              done,
    output logic [NOTE_W-1:0] code,
    output logic              matched
);

    logic              busy;
    logic              found;
    logic [NOTE_W-1:0] k;
    logic [NOTE_W-1:0] found_code;
    logic [M_W-1:0]    m_q;
    logic [M_W-1:0]    d;
    logic [11:0]       diff;
    logic              hit;

    always_comb begin
        d       = note_div(k);
        diff    = (m_q >= d) ? ({1'b0, m_q} - {1'b0, d}) : ({1'b0, d} - {1'b0, m_q});
        hit     = busy && (diff <= {6'd0, d[M_W-1:5]});
        done    = busy && (k == NOTE_W'(NUM_NOTES));
        matched = found || hit;
        code    = found ? found_code : (hit ? k : NOTE_SILENCE);
    end

    // A new start restarts the walk even if a search is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            found      <= 1'b0;
            k          <= '0;
            found_code <= '0;
            m_q        <= '0;
        end else if (start) begin
            busy       <= 1'b1;
            found      <= 1'b0;
            k          <= 5'd1;
            found_code <= '0;
            m_q        <= m;
        end else if (busy) begin
            if (hit && !found) begin
                found      <= 1'b1;
                found_code <= k;
            end
            if (done) busy <= 1'b0;
            else      k    <= k + 1'b1;
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// Measures the period of a 1-bit tone, matches it against the note table and
// emits one event per stable note change with the previous note's duration.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int SHIFT     = 7,
    parameter int STABLE    = 4,
    parameter int BEAT_LOG2 = 22,
    parameter int CNT_W     = 18   // period counter width; cnt[SHIFT +: 11] is the unit field
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tone_in,
    output logic              event_valid,
    output logic [NOTE_W-1:0] event_note,
    output logic [7:0]        event_dur,
    output logic [NOTE_W-1:0] locked_note
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]           sync_q;
    logic                 rise;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_p1;
    logic                 sat;
    logic [M_W-1:0]       m;
    logic                 start;
    logic                 done;
    logic                 matched;
    logic [NOTE_W-1:0]    code;
    dec_state_t           state, state_n;
    logic [NOTE_W-1:0]    cand, cand_n;
    logic [3:0]           stab, stab_n;
    logic                 fire;
    logic [NOTE_W-1:0]    fire_note;
    logic [BEAT_LOG2-1:0] pre;
    logic                 tick;
    logic [7:0]           beat;

    // cnt lags the true elapsed count by one, so capture from cnt_p1.
    always_comb begin
        rise   = sync_q[1] & ~sync_q[2];
        cnt_p1 = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        sat    = (cnt == CNT_MAX) && !rise;
        m      = cnt_p1[SHIFT +: M_W];
        start  = rise && (state != ST_IDLE);
        tick   = &pre;
    end

    note_matcher u_matcher (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .m       (m),
        .done    (done),
        .code    (code),
        .matched (matched)
    );

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        stab_n    = stab;
        fire      = 1'b0;
        fire_note = NOTE_SILENCE;
        if (sat) begin
            state_n = ST_IDLE;
            cand_n  = NOTE_SILENCE;
            stab_n  = '0;
            fire    = (locked_note != NOTE_SILENCE);
        end else begin
            case (state)
                ST_IDLE:    if (rise) state_n = ST_MEASURE;
                ST_MEASURE: if (rise) state_n = ST_SEARCH;
                ST_SEARCH: begin
                    if (rise) begin
                        // abandoned search counts as unmatched; new one already started
                        cand_n = NOTE_SILENCE;
                        stab_n = '0;
                    end else if (done) begin
                        state_n = ST_MEASURE;
                        if (!matched) begin
                            cand_n = NOTE_SILENCE;
                            stab_n = '0;
                        end else if (code == cand) begin
                            stab_n = (stab == 4'd15) ? stab : stab + 4'd1;
                        end else begin
                            cand_n = code;
                            stab_n = 4'd1;
                        end
                        if (stab_n >= 4'(STABLE) && cand_n != locked_note) begin
                            fire      = 1'b1;
                            fire_note = cand_n;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            cnt         <= '0;
            state       <= ST_IDLE;
            cand        <= '0;
            stab        <= '0;
            event_valid <= 1'b0;
            event_note  <= '0;
            event_dur   <= '0;
            locked_note <= '0;
            pre         <= '0;
            beat        <= '0;
        end else begin
            sync_q      <= {sync_q[1:0], tone_in};
            cnt         <= rise ? '0 : cnt_p1;
            state       <= state_n;
            cand        <= cand_n;
            stab        <= stab_n;
            event_valid <= fire;
            pre         <= pre + 1'b1;
            if (fire) begin
                event_note  <= fire_note;
                event_dur   <= beat;
                locked_note <= fire_note;
                beat        <= '0;
            end else if (tick && beat != 8'hff) begin
                beat <= beat + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: table of tone trains plus hand-written
// timing sequences (lock latency, glitch abort, silence, mid-stream reset).
module tb_tone_decoder;

    localparam int SHIFT_T  = 1;
    localparam int CNT_W_T  = 12;
    localparam int BEAT_L_T = 8;
    localparam int BEAT     = 1 << BEAT_L_T;
    localparam int TMO      = 1 << CNT_W_T;

    logic       clk = 1'b0;
    logic       rst;
    logic       tone_in;
    logic       event_valid;
    logic [4:0] event_note;
    logic [7:0] event_dur;
    logic [4:0] locked_note;

    int pc = 0;
    int ev_cnt = 0;
    int last_ev_pc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        int         period;
        int         n;
        int         exp_ev;
        logic [4:0] exp_note;
        logic [4:0] exp_locked;
    } vec_t;

    vec_t vecs[8];

    tone_decoder #(
        .SHIFT     (SHIFT_T),
        .STABLE    (4),
        .BEAT_LOG2 (BEAT_L_T),
        .CNT_W     (CNT_W_T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tone_in     (tone_in),
        .event_valid (event_valid),
        .event_note  (event_note),
        .event_dur   (event_dur),
        .locked_note (locked_note)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pc <= rst ? 0 : pc + 1;

    always @(negedge clk) begin
        if (!rst && event_valid) begin
            ev_cnt     <= ev_cnt + 1;
            last_ev_pc <= pc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // n rising edges spaced p clocks apart; first = pc at the first edge.
    task automatic edges(input int p, input int n, output int first);
        first = pc;
        for (int i = 0; i < n; i++) begin
            tone_in = 1'b1;
            repeat (p / 2) @(negedge clk);
            tone_in = 1'b0;
            repeat (p - p / 2) @(negedge clk);
        end
    endtask

    // Ticks land on posedges n with n % BEAT == 0; the tick on the event edge is lost.
    function automatic int dur_model(input int t_prev, input int t_ev);
        int b;
        b = (t_ev - 1) / BEAT - t_prev / BEAT;
        return (b > 255) ? 255 : b;
    endfunction

    initial begin
        int f, c0, t1, t2, t5, s, x, lo, hi;
        // periods in clocks (unit = 2 clocks); each train continues the previous one
        vecs[0] = '{772,  3, 0, 5'd10, 5'd10};   // 386: low tolerance edge of code 10
        vecs[1] = '{630,  3, 0, 5'd10, 5'd10};   // code 12 candidate builds to 2
        vecs[2] = '{770,  2, 0, 5'd10, 5'd10};   // 385: unmatched, candidate cleared
        vecs[3] = '{630,  4, 0, 5'd10, 5'd10};   // code 12 restarts from 1
        vecs[4] = '{820,  2, 1, 5'd12, 5'd12};   // 4th period of 12 locks; 410 hits code 9 first
        vecs[5] = '{820,  4, 1, 5'd9,  5'd9};
        vecs[6] = '{1896, 5, 1, 5'd1,  5'd1};
        vecs[7] = '{396,  5, 1, 5'd17, 5'd17};

        rst = 1'b1;
        tone_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", event_valid, 0);
        check("rst_note", event_note, 0);
        check("rst_dur", event_dur, 0);
        check("rst_locked", locked_note, 0);
        rst = 1'b0;

        // code 10 lock: event 18 cycles after the 5th edge reaches the detector
        c0 = ev_cnt;
        edges(796, 6, f);
        check("lock10_count", ev_cnt - c0, 1);
        check("lock10_time", last_ev_pc, f + 4 * 796 + 20);
        check("lock10_note", event_note, 10);
        check("lock10_locked", locked_note, 10);

        for (int i = 0; i < 8; i++) begin
            c0 = ev_cnt;
            edges(vecs[i].period, vecs[i].n, f);
            check($sformatf("vec%0d_events", i), ev_cnt - c0, vecs[i].exp_ev);
            check($sformatf("vec%0d_note", i), event_note, vecs[i].exp_note);
            check($sformatf("vec%0d_locked", i), locked_note, vecs[i].exp_locked);
        end

        // note change 7 -> 12 with duration
        c0 = ev_cnt;
        edges(1062, 10, f);
        check("lock7_time", last_ev_pc, f + 4 * 1062 + 20);
        check("lock7_note", event_note, 7);
        t1 = last_ev_pc;
        edges(630, 5, f);
        t2 = last_ev_pc;
        check("chg_count", ev_cnt - c0, 2);
        check("chg_note", event_note, 12);
        check("chg_dur", event_dur, dur_model(t1, t2));

        // glitch 8 cycles after an edge aborts that search
        c0 = ev_cnt;
        edges(1264, 3, f);
        x = pc;
        tone_in = 1'b1;
        repeat (4) @(negedge clk);
        tone_in = 1'b0;
        repeat (4) @(negedge clk);
        tone_in = 1'b1;
        repeat (632 - 8) @(negedge clk);
        tone_in = 1'b0;
        repeat (632) @(negedge clk);
        check("glitch_pre_events", ev_cnt - c0, 0);
        edges(1264, 4, f);
        check("glitch_count", ev_cnt - c0, 1);
        check("glitch_time", last_ev_pc, f + 3 * 1264 + 20);
        check("glitch_note", event_note, 5);
        check("glitch_locked", locked_note, 5);
        t5 = last_ev_pc;

        // silence after timeout, once only
        s = f + 3 * 1264;
        c0 = ev_cnt;
        while (ev_cnt == c0 && pc < s + TMO + 300) @(negedge clk);
        check("sil_count", ev_cnt - c0, 1);
        lo = s + TMO;
        hi = s + TMO + 4;
        n_checks++;
        if (last_ev_pc >= lo && last_ev_pc <= hi) n_pass++;
        else $display("FAIL sil_time: got %0d expected %0d..%0d", last_ev_pc, lo, hi);
        check("sil_note", event_note, 0);
        check("sil_locked", locked_note, 0);
        check("sil_dur", event_dur, dur_model(t5, last_ev_pc));
        repeat (1000) @(negedge clk);
        check("sil_quiet", ev_cnt - c0, 1);

        // relock from idle, then reset in the middle of a search
        c0 = ev_cnt;
        edges(796, 6, f);
        check("relock_time", last_ev_pc, f + 4 * 796 + 20);
        check("relock_note", locked_note, 10);
        x = pc;
        tone_in = 1'b1;
        repeat (3) @(negedge clk);
        tone_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_valid", event_valid, 0);
        check("mrst_note", event_note, 0);
        check("mrst_dur", event_dur, 0);
        check("mrst_locked", locked_note, 0);
        rst = 1'b0;
        c0 = ev_cnt;
        repeat (790) @(negedge clk);
        check("mrst_no_event", ev_cnt - c0, 0);
        edges(796, 5, f);
        check("mrst_relock_count", ev_cnt - c0, 1);
        check("mrst_relock_time", last_ev_pc, f + 4 * 796 + 20);
        check("mrst_relock_note", locked_note, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
